register_sync_arbiter: RTL and testbench
========================================

Name: register_sync_arbiter

Overview:
- Single-clock front end that multiplexes NCH independently written control registers onto one en/ack register-synchronizer channel, so one crossing carries many registers.
- Sits in the source (management/JTAG) domain.
- Holds a shadow copy per channel and coalesces repeated writes into one transfer of the latest value.
- Round-robin serves pending channels and reports per-channel completion when the far side acks.

Parameters:
- WIDTH, 16, data bits per register.
- NCH, 4, number of register channels (>=1).
- INIT, 0, reset value of shadows and sync_data.
- TIMEOUT, 1024, ack timeout in cycles; used only with the optional feature.
- Derived CW = max(1, $clog2(NCH)).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NCH  per-channel write strobe.
- wr_data  in  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- pending  out  NCH  channel i has an unsent or unacked-and-rewritten value.
- busy  out  1  state != IDLE or |pending.
- sync_en  out  1  single-cycle transfer request to the downstream synchronizer.
- sync_chan  out  CW  channel index of the current transfer.
- sync_data  out  WIDTH  value being transferred.
- sync_ack  in  1  single-cycle completion from the downstream synchronizer.
- done  out  NCH  one-cycle pulse per channel when its transfer is acked.
- timeout_err  out  1  sticky ack-timeout flag.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending, done, sync_en, sync_chan, timeout_err all 0.
  - shadow[i]=INIT and sync_data=INIT.
  - rr pointer = NCH-1, so channel 0 has first priority.
- Write:
  - wr_en[i] at edge N: shadow[i]<=wr_data[i] and pending[i]<=1, visible at cycle N+1.
  - Simultaneous writes to different channels all accepted.
- IDLE:
  - If |pending, grant the first set bit searching from (rr+1) mod NCH upward with wrap.
  - On the grant edge: sync_data<=shadow[g], sync_chan<=g, rr<=g, sync_en<=1 for one cycle, state<=WAIT.
  - pending[g] cleared on the grant edge unless wr_en[g] in the same cycle. In that case pending stays set, shadow takes the new value, and sync_data takes the old value.
  - sync_ack in IDLE is ignored.
- WAIT:
  - sync_ack is sampled every cycle, including the sync_en cycle.
  - On ack: done[sync_chan] pulses the next cycle and state<=IDLE.
  - sync_data and sync_chan are held constant from sync_en until the edge after ack, as the downstream synchronizer requires with no input register.
- Latency and spacing:
  - wr_en at cycle N to sync_en at N+2 minimum (pending registered, then grant).
  - Minimum spacing between successive sync_en pulses is 2 cycles.
- Coalescing:
  - K writes to one channel before its grant produce a single transfer carrying the last value.
  - Writes during that channel's own WAIT set pending again. That channel is re-sent after ack, at its next round-robin turn.
- NCH=1:
  - sync_chan is constant 0.
  - The arbiter degenerates to a single-channel update queue.
- Reset mid-WAIT: the transfer is abandoned and nothing is retried. System reset must also reset the downstream synchronizer.

Optional Feature:
- Macro REGSYNC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on sync_en and increments each WAIT cycle.
  - Reaching TIMEOUT with no ack sets timeout_err (sticky until reset), re-sets pending[sync_chan] for retry, and returns to IDLE with no done pulse.
  - A late ack arriving in IDLE is ignored.
- Undefined: no counter; timeout_err is tied 0; WAIT waits indefinitely.

Test Plan:
1. Reset, then wr_en[2]=1 with data 0xBEEF at cycle 0 -> sync_en=1 at cycle 2 with sync_chan=2 and sync_data=0xBEEF. Ack at cycle 5 -> done[2] at cycle 6; pending=0 and busy=0 at cycle 6.
2. All 4 channels written in the same cycle, ack returned 3 cycles after each sync_en -> grants in order 0,1,2,3; each done pulse once; the next round after rr=3 starts at channel 0.
3. Channel 1 written 0x1111, 0x2222, 0x3333 on consecutive cycles while channel 0 is in WAIT -> exactly one channel-1 transfer, carrying 0x3333.
4. Channel 0 written 0xAAAA; during its WAIT, written 0x5555 -> sync_data holds 0xAAAA until ack; a second transfer follows with 0x5555; done[0] pulses twice.
5. sync_ack pulsed while IDLE -> no done pulse, no state change. rst_n asserted during WAIT -> all outputs return to reset values asynchronously, and no transfer follows release.
6. With REGSYNC_ARB_TIMEOUT_EN and TIMEOUT=8, ack withheld -> timeout_err=1 after 8 WAIT cycles, channel retried with sync_en again. Ack given on the retry -> done pulses; timeout_err stays 1.

Source files
------------

// File: rtl/register_sync_arbiter.sv
// Multiplexes NCH shadowed control registers onto one en/ack register-synchronizer channel.
// Optional ack timeout with retry is enabled by defining REGSYNC_ARB_TIMEOUT_EN.
module register_sync_arbiter #(
  parameter int              WIDTH   = 16,
  parameter int              NCH     = 4,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int              TIMEOUT = 1024,
  localparam int             CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       wr_en,
  input  logic [NCH*WIDTH-1:0] wr_data,
  output logic [NCH-1:0]       pending,
  output logic                 busy,
  output logic                 sync_en,
  output logic [CW-1:0]        sync_chan,
  output logic [WIDTH-1:0]     sync_data,
  input  logic                 sync_ack,
  output logic [NCH-1:0]       done,
  output logic                 timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]                 state;
  logic [CW-1:0]              rr;
  logic [NCH-1:0][WIDTH-1:0]  shadow;
  logic [NCH-1:0]             pending_nxt;
  logic                       gnt_vld;
  logic [CW-1:0]              gnt;
  logic                       grant;
  logic                       to_fire;

  // Per-channel shadow registers
  for (genvar i = 0; i < NCH; i++) begin : g_shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       shadow[i] <= INIT;
      else if (wr_en[i]) shadow[i] <= wr_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search from rr+1 with wrap; descending k leaves the nearest hit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NCH; k >= 1; k--) begin
      int idx;
      idx = (int'(rr) + k) % NCH;
      if (pending[idx]) begin
        gnt_vld = 1'b1;
        gnt     = CW'(idx);
      end
    end
  end

  assign grant = (state == IDLE) && gnt_vld;

  // A write in the grant cycle wins over the clear, so the new value is re-sent later.
  always_comb begin
    pending_nxt = pending;
    if (grant)   pending_nxt[gnt] = 1'b0;
    if (to_fire) pending_nxt[sync_chan] = 1'b1;
    pending_nxt = pending_nxt | wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= CW'(NCH - 1);
      pending   <= '0;
      sync_en   <= 1'b0;
      sync_chan <= '0;
      sync_data <= INIT;
      done      <= '0;
    end else begin
      pending <= pending_nxt;
      sync_en <= 1'b0;
      done    <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            sync_data <= shadow[gnt];
            sync_chan <= gnt;
            rr        <= gnt;
            sync_en   <= 1'b1;
            state     <= WAIT;
          end
        end
        default: begin
          if (sync_ack) begin
            done[sync_chan] <= 1'b1;
            state           <= IDLE;
          end else if (to_fire) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef REGSYNC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_fire = (state == WAIT) && !sync_ack && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant)                 to_cnt <= '0;
      else if (state == WAIT)    to_cnt <= to_cnt + 1'b1;
      if (to_fire)               timeout_err <= 1'b1;
    end
  end
`else
  assign to_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_register_sync_arbiter.sv
// Bench for register_sync_arbiter: write-pattern table plus hand sequences, scoreboard on sync_en.
module tb_register_sync_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   wr_en = '0;
  logic [N*W-1:0] wr_data = '0;
  logic [N-1:0]   pending;
  logic           busy;
  logic           sync_en;
  logic [1:0]     sync_chan;
  logic [W-1:0]   sync_data;
  logic           sync_ack = 1'b0;
  logic [N-1:0]   done;
  logic           timeout_err;

  always #5 clk = ~clk;

  register_sync_arbiter #(.WIDTH(W), .NCH(N), .INIT('0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .pending(pending), .busy(busy), .sync_en(sync_en), .sync_chan(sync_chan),
    .sync_data(sync_data), .sync_ack(sync_ack), .done(done), .timeout_err(timeout_err)
  );

  typedef struct packed { logic [1:0] ch; logic [15:0] data; } exp_t;
  typedef struct { logic [3:0] mask; int n; int order [4]; } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt[N];
  bit   auto_ack = 1'b0;
  int   ack_dly = 3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops on sync_en, checks hold while waiting and done pulses.
  logic       in_xfer = 1'b0;
  exp_t       cur;
  logic [N-1:0] exp_done = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      in_xfer  = 1'b0;
      exp_done = '0;
    end else begin
      chk("done", done, exp_done);
      exp_done = '0;
      for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
      if (sync_en) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sync_en actual chan=%0d data=%0h required=no transfer", sync_chan, sync_data);
          cur = '{sync_chan, sync_data};
        end else begin
          cur = sbq.pop_front();
          chk("sync_chan", sync_chan, cur.ch);
          chk("sync_data", sync_data, cur.data);
        end
        in_xfer = 1'b1;
      end else if (in_xfer) begin
        chk("hold_chan", sync_chan, cur.ch);
        chk("hold_data", sync_data, cur.data);
      end
      if (in_xfer && sync_ack) begin
        exp_done = 4'(1) << cur.ch;
        in_xfer  = 1'b0;
      end
    end
  end

  // Downstream synchronizer model: ack ack_dly cycles after each sync_en.
  initial forever begin
    @(negedge clk);
    if (auto_ack && sync_en && rst_n) begin
      repeat (ack_dly) @(posedge clk);
      #1 sync_ack = 1'b1;
      @(posedge clk);
      #1 sync_ack = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; wr_en = '0; sync_ack = 1'b0;
    sbq.delete();
    repeat (2) step();
    chk("rst_pending", pending, 4'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sync_en", sync_en, 1'b0);
    chk("rst_sync_data", sync_data, 16'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_idle actual=busy required=idle within 300 cycles");
    end
    repeat (2) step();
  endtask

  task automatic wait_sync_en();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (sync_en) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_sync_en actual=none required=sync_en within 50 cycles");
    end
  endtask

  task automatic wr1(input int ch, input logic [15:0] d);
    wr_en = '0;
    wr_en[ch] = 1'b1;
    wr_data[ch*W +: W] = d;
  endtask

  task automatic set_vec(input int k, input logic [3:0] m, input int n,
                         input int o0, input int o1, input int o2, input int o3);
    vecs[k].mask = m; vecs[k].n = n;
    vecs[k].order[0] = o0; vecs[k].order[1] = o1;
    vecs[k].order[2] = o2; vecs[k].order[3] = o3;
  endtask

  int base[N];
  logic [15:0] d[N];

  initial begin
    // Expected grant order per write mask, given rr left by the previous row.
    set_vec(0, 4'b1111, 4, 0, 1, 2, 3);
    set_vec(1, 4'b1111, 4, 0, 1, 2, 3);
    set_vec(2, 4'b0100, 1, 2, 0, 0, 0);
    set_vec(3, 4'b1010, 2, 3, 1, 0, 0);
    set_vec(4, 4'b0101, 2, 2, 0, 0, 0);
    set_vec(5, 4'b0011, 2, 1, 0, 0, 0);
    set_vec(6, 4'b1001, 2, 3, 0, 0, 0);
    for (int i = 0; i < N; i++) done_cnt[i] = 0;

    // Single write: latency 2 to sync_en, manual ack, done next cycle.
    do_reset();
    step();
    wr1(2, 16'hBEEF); sbq.push_back('{2'd2, 16'hBEEF});
    step(); wr_en = '0;
    @(negedge clk);
    chk("t1_sync_en_c1", sync_en, 1'b0);
    chk("t1_pending_c1", pending, 4'b0100);
    chk("t1_busy_c1", busy, 1'b1);
    step(); @(negedge clk);
    chk("t1_sync_en_c2", sync_en, 1'b1);
    step(); step(); step();
    sync_ack = 1'b1;
    step(); sync_ack = 1'b0;
    @(negedge clk);
    chk("t1_done_c6", done, 4'b0100);
    chk("t1_pending_c6", pending, 4'b0);
    chk("t1_busy_c6", busy, 1'b0);
    repeat (2) step();

    // Table of simultaneous write patterns with automatic ack.
    do_reset();
    auto_ack = 1'b1; ack_dly = 3;
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < N; i++) begin
        base[i] = done_cnt[i];
        d[i] = 16'($urandom);
      end
      step();
      wr_en = vecs[k].mask;
      for (int i = 0; i < N; i++) wr_data[i*W +: W] = d[i];
      for (int j = 0; j < vecs[k].n; j++)
        sbq.push_back('{2'(vecs[k].order[j]), d[vecs[k].order[j]]});
      step(); wr_en = '0;
      wait_idle();
      for (int i = 0; i < N; i++)
        chk($sformatf("vec%0d_done_cnt%0d", k, i), done_cnt[i] - base[i], 64'(vecs[k].mask[i]));
    end

    // Coalescing: three writes to ch1 while ch0 waits -> one transfer of the last.
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
    step();
    wr1(0, 16'h0123); sbq.push_back('{2'd0, 16'h0123}); sbq.push_back('{2'd1, 16'h3333});
    step(); wr_en = '0;
    step(); wr1(1, 16'h1111);
    step(); wr1(1, 16'h2222);
    step(); wr1(1, 16'h3333);
    step(); wr_en = '0;
    wait_idle();
    chk("coal_done_ch1", done_cnt[1] - base[1], 1);
    chk("coal_done_ch0", done_cnt[0] - base[0], 1);

    // Rewrite during own WAIT: old value held, new value re-sent.
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
    step();
    wr1(0, 16'hAAAA); sbq.push_back('{2'd0, 16'hAAAA}); sbq.push_back('{2'd0, 16'h5555});
    step(); wr_en = '0;
    step(); step(); wr1(0, 16'h5555);
    step(); wr_en = '0;
    wait_idle();
    chk("rewrite_done_ch0", done_cnt[0] - base[0], 2);

    // Rewrite on the grant edge itself: pending survives the grant.
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
    step();
    wr1(0, 16'hA5A5); sbq.push_back('{2'd0, 16'hA5A5}); sbq.push_back('{2'd0, 16'h5A5A});
    step(); wr1(0, 16'h5A5A);
    step(); wr_en = '0;
    @(negedge clk);
    chk("grant_edge_pending", pending, 4'b0001);
    wait_idle();
    chk("grant_edge_done_ch0", done_cnt[0] - base[0], 2);

    // Stray ack in IDLE is ignored.
    auto_ack = 1'b0;
    step(); sync_ack = 1'b1;
    step(); sync_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_done", done, 4'b0);
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_sync_en", sync_en, 1'b0);

    // Async reset during WAIT abandons the transfer.
    step();
    wr1(3, 16'h7777); sbq.push_back('{2'd3, 16'h7777});
    step(); wr_en = '0;
    wait_sync_en();
    step(); wr1(1, 16'h1234);
    step(); wr_en = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pending", pending, 4'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sync_en", sync_en, 1'b0);
    chk("midrst_sync_chan", sync_chan, 2'd0);
    chk("midrst_sync_data", sync_data, 16'h0);
    chk("midrst_done", done, 4'b0);
    sbq.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);

    // Ack withheld.
    for (int i = 0; i < N; i++) base[i] = done_cnt[i];
    step();
    wr1(1, 16'h4242); sbq.push_back('{2'd1, 16'h4242});
`ifdef REGSYNC_ARB_TIMEOUT_EN
    sbq.push_back('{2'd1, 16'h4242});
`endif
    step(); wr_en = '0;
    wait_sync_en();
`ifdef REGSYNC_ARB_TIMEOUT_EN
    repeat (7) step();
    @(negedge clk);
    chk("to_err_before", timeout_err, 1'b0);
    step(); @(negedge clk);
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_pending_retry", pending, 4'b0010);
    step(); @(negedge clk);
    chk("to_retry_sync_en", sync_en, 1'b1);
`else
    repeat (20) step();
    @(negedge clk);
    chk("noto_err", timeout_err, 1'b0);
    chk("noto_busy", busy, 1'b1);
`endif
    step(); sync_ack = 1'b1;
    step(); sync_ack = 1'b0;
    @(negedge clk);
    chk("ack_done_ch1", done, 4'b0010);
`ifdef REGSYNC_ARB_TIMEOUT_EN
    chk("to_err_sticky", timeout_err, 1'b1);
`else
    chk("noto_err_after", timeout_err, 1'b0);
`endif
    wait_idle();
    chk("ack_done_cnt_ch1", done_cnt[1] - base[1], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
